fetch_unit: RTL
===============

# fetch_unit

Parametrised instruction fetch stage: a wrapping program counter drives an external combinational program ROM. Fetched bytes go into a small prefetch queue with a valid/ready handshake toward decode. A load (jump) flushes the queue and redirects the PC. It replaces the fixed 12-bit counter / 8-bit fetch-register pair. It sits between program memory and the decode/control FSM.

## Interface
- `ADDR_W`, 12, program counter and ROM address width.
- `INSTR_W`, 4, opcode field width (upper bits of a program word).
- `OPERAND_W`, 4, operand field width (lower bits); `DATA_W = INSTR_W + OPERAND_W`.
- `DEPTH`, 2, prefetch queue entries; power of two, 1..16.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `enable` in 1: fetch enable; 0 freezes PC and stops pushes, pops still allowed.
- `load` in 1: redirect request, sampled at rising edge.
- `load_addr` in ADDR_W: new PC when `load`=1.
- `mem_addr` out ADDR_W: ROM address, equals current PC register.
- `mem_data` in DATA_W: ROM word for `mem_addr`, combinational, same cycle.
- `instr_valid` out 1: queue head holds a valid word.
- `instr_ready` in 1: decode accepts head this cycle.
- `instr` out INSTR_W: `head.data[DATA_W-1:OPERAND_W]`.
- `operand` out OPERAND_W: `head.data[OPERAND_W-1:0]`.
- `instr_pc` out ADDR_W: address the head word was fetched from.
- `pc` out ADDR_W: current PC (same as `mem_addr`).

## Operation
- Reset values: PC=0, queue count=0, `instr_valid`=0, `instr`/`operand`/`instr_pc`=0 (entry storage cleared).
- `pop` = `instr_valid & instr_ready`.
- `push` = `enable & !load & (count<DEPTH | pop)`.
- Each push stores `{mem_data, pc}` at tail. PC <= PC+1 modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0.
- Push and pop in the same cycle when full: allowed, count unchanged.
- Pop from empty is impossible because `instr_valid`=0.
- Load has priority over everything:
  - PC <= `load_addr` and count <= 0.
  - No push that cycle; any simultaneous pop is discarded (entry flushed, not delivered).
- `enable`=0 with `load`=1 still redirects and flushes.
- Outputs are driven from registered queue storage/pointers only. No combinational path exists from `mem_data` or `instr_ready` to `instr`/`operand`/`instr_valid`.
- `instr_valid` = (count != 0).

## Timing
- Reset release: `mem_addr`=0 immediately. The first push occurs at the first edge with `enable`=1. `instr_valid` rises after that edge (1-cycle fetch latency).
- Load sampled at edge T:
  - `mem_addr`=`load_addr` and `instr_valid`=0 during cycle T..T+1.
  - Word at `load_addr` is pushed at edge T+1 and valid after T+1.
  - Load-to-valid latency: 2 edges.
- Steady state with `instr_ready`=1 and `enable`=1: one instruction per cycle, consecutive addresses.
- Backpressure (`instr_ready`=0): queue fills to DEPTH in DEPTH cycles, then PC holds. On release, throughput returns to 1/cycle with no bubble.
- Async reset mid-operation: queue and PC cleared without waiting for a clock edge. Outputs return to reset values the same cycle.

## Structure
- Package `fetch_pkg`:
  - derived `DATA_W` function;
  - `fetch_entry_t` struct {data, addr}, parametrised through localparams;
  - reset constants.
- Sub-module `fetch_queue`: DEPTH-entry circular FIFO with push/pop/flush, count, head outputs, async reset.
- The top-level holds the PC register and push/pop/load control only.

## Test plan
- Reset, `enable`=1, `instr_ready`=1, ROM[n]=n+0x10 → outputs 0x10, 0x11, 0x12 on successive cycles. First valid is 1 cycle after the first edge, with `instr_pc`=0,1,2.
- `instr_ready`=0 for 5 cycles, DEPTH=2 → count saturates at 2 and PC stops at 2. After release, words 0,1,2,3 come out back-to-back with no gap or duplicate.
- `load`=1, `load_addr`=0x0A5 while 2 entries are queued and `instr_ready`=1 → the queued entries are never delivered. `instr_valid`=0 for 2 edges, then `instr_pc`=0x0A5 followed by 0x0A6.
- PC preset via load to 0xFFE, free run → `instr_pc` sequence 0xFFE, 0xFFF, 0x000, 0x001.
- `enable`=0 with 1 entry queued and `instr_ready`=1 → the entry pops, `instr_valid` falls, PC frozen. Re-enable resumes at the frozen PC.
- Assert `reset` asynchronously between edges mid-stream → `instr_valid`, `pc`, `instr`, `operand` read 0 before the next edge. Run again with ADDR_W=8, DEPTH=4, INSTR_W=OPERAND_W=8.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default geometry,
// the derived program-word width, the queue entry layout and reset values.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF    = 12;
  localparam int unsigned INSTR_W_DEF   = 4;
  localparam int unsigned OPERAND_W_DEF = 4;
  localparam int unsigned DEPTH_DEF     = 2;

  // A program word is the opcode field on top of the operand field.
  function automatic int unsigned data_w(input int unsigned instr_w,
                                         input int unsigned operand_w);
    return instr_w + operand_w;
  endfunction

  localparam int unsigned DATA_W_DEF = data_w(INSTR_W_DEF, OPERAND_W_DEF);

  // Queue entry for the default geometry: the fetched word plus the address
  // it came from. The queue builds the same {data, addr} layout from its own
  // parameters so other geometries share one definition of field order.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [ADDR_W_DEF-1:0] addr;
  } fetch_entry_t;

  // Reset values.
  localparam int unsigned RESET_PC    = 0;
  localparam int unsigned RESET_COUNT = 0;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry circular prefetch FIFO holding {data, addr} pairs.
// Flush empties the queue and wins over push/pop in the same cycle.
// Head outputs come straight from registered storage and pointers.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  output logic              valid_o,
  output logic              full_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [ADDR_W-1:0] head_addr_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next pointer/count values; flush resets both pointers and the count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = CNT_W'(RESET_COUNT);
    end else begin
      if (push_i) tail_d = ptr_inc(tail_q);
      if (pop_i)  head_d = ptr_inc(head_q);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_W'(RESET_COUNT);
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; written at the tail on every push not cancelled by flush.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the storage array is reset on purpose because the head word is
    // visible on instr/operand/instr_pc and must read zero out of reset.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[tail_q] <= '{data: push_data_i, addr: push_addr_i};
    end
  end

  assign valid_o     = (count_q != '0);
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign head_data_o = mem_q[head_q].data;
  assign head_addr_o = mem_q[head_q].addr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: a wrapping PC addresses an external combinational
// ROM, fetched words are queued toward decode, and a load redirects the PC
// while flushing everything already queued.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter  int unsigned ADDR_W    = ADDR_W_DEF,
  parameter  int unsigned INSTR_W   = INSTR_W_DEF,
  parameter  int unsigned OPERAND_W = OPERAND_W_DEF,
  parameter  int unsigned DEPTH     = DEPTH_DEF,
  localparam int unsigned DATA_W    = data_w(INSTR_W, OPERAND_W)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load,
  input  logic [ADDR_W-1:0]    load_addr,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [INSTR_W-1:0]   instr,
  output logic [OPERAND_W-1:0] operand,
  output logic [ADDR_W-1:0]    instr_pc,
  output logic [ADDR_W-1:0]    pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pop, push;
  logic              q_valid, q_full;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_addr;

  // A full queue still accepts a push when its head leaves the same cycle,
  // which keeps throughput at one word per cycle after backpressure.
  assign pop  = q_valid & instr_ready;
  assign push = enable & ~load & (~q_full | pop);

  // Next PC: load wins, otherwise advance (wrapping) only when a word is taken.
  always_comb begin
    pc_d = pc_q;
    if (load)      pc_d = load_addr;
    else if (push) pc_d = pc_q + ADDR_W'(1);
  end

  // Program counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= ADDR_W'(RESET_PC);
    else       pc_q <= pc_d;
  end

  fetch_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (reset),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (load),
    .push_data_i (mem_data),
    .push_addr_i (pc_q),
    .valid_o     (q_valid),
    .full_o      (q_full),
    .head_data_o (head_data),
    .head_addr_o (head_addr)
  );

  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr_valid = q_valid;
  assign instr       = head_data[DATA_W-1:OPERAND_W];
  assign operand     = head_data[OPERAND_W-1:0];
  assign instr_pc    = head_addr;

endmodule
